// File: rtl/load_ext_pipe.sv
// load_ext_pipe
//   Two-stage elastic load-data extender placed between data-memory read
//   data and the MEM/WB register. Stage 1 selects the addressed byte, half,
//   word or dword lane from the memory word and flags misaligned or illegal
//   accesses. Stage 2 sign- or zero-extends the lane to the full datapath
//   width. A tag is carried alongside each request.
//
// Parameters
//   WIDTH  datapath / memory word width (32 or 64)
//   TAG_W  width of the pass-through tag
//   OFF_W  byte-offset width, derived from WIDTH
//
// Ports
//   clk        rising-edge clock
//   rst        synchronous active-high reset
//   in_valid   request valid
//   in_ready   unit can accept a request this cycle
//   in_data    raw memory word
//   in_off     byte offset of the access within the word (little-endian)
//   in_size    0 byte, 1 half, 2 word, 3 dword
//   in_sign    1 sign-extend, 0 zero-extend
//   in_tag     tag carried unchanged to the output
//   out_valid  result valid
//   out_ready  consumer accepts result
//   out_data   extended load result (0 when out_err is set)
//   out_tag    tag of the result
//   out_err    misaligned access or illegal size
module load_ext_pipe #(
  parameter  int WIDTH = 32,
  parameter  int TAG_W = 5,
  localparam int OFF_W = $clog2(WIDTH / 8)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [OFF_W-1:0] in_off,
  input  logic [1:0]       in_size,
  input  logic             in_sign,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_err
);

  typedef enum logic [1:0] {
    SZ_B = 2'd0,
    SZ_H = 2'd1,
    SZ_W = 2'd2,
    SZ_D = 2'd3
  } size_e;

  // Stage 1 registers
  logic             s1_valid;
  logic [WIDTH-1:0] s1_lane;
  size_e            s1_size;
  logic             s1_sign;
  logic [TAG_W-1:0] s1_tag;
  logic             s1_err;

  // Stage 2 registers (drive the outputs directly)
  logic             s2_valid;
  logic [WIDTH-1:0] s2_data;
  logic [TAG_W-1:0] s2_tag;
  logic             s2_err;

  // Handshake
  logic s1_adv;
  logic s2_adv;
  logic s1_load;
  logic s2_load;

  // Stage 1 combinational
  logic [WIDTH-1:0] shifted;
  logic [WIDTH-1:0] size_mask;
  logic [WIDTH-1:0] lane_d;
  logic [OFF_W-1:0] align_mask;
  logic             err_d;

  // Stage 2 combinational
  logic [WIDTH-1:0] ext_mask;
  logic             lane_msb;
  logic [WIDTH-1:0] ext_d;

  assign s2_adv   = !s2_valid || out_ready;
  assign s1_adv   = !s1_valid || s2_adv;
  assign in_ready = s1_adv;
  assign s1_load  = in_valid && s1_adv;
  assign s2_load  = s1_valid && s2_adv;

  // Lane selection and alignment check. The alignment mask has the low
  // log2(access bytes) offset bits set; any of those set in in_off means
  // the access straddles its natural boundary.
  always_comb begin
    shifted    = in_data >> {in_off, 3'b000};
    size_mask  = '0;
    align_mask = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (i < (32'd8 << in_size)) begin
        size_mask[i] = 1'b1;
      end
    end
    for (int unsigned i = 0; i < OFF_W; i++) begin
      if (i < 32'(in_size)) begin
        align_mask[i] = 1'b1;
      end
    end
    lane_d = shifted & size_mask;
    err_d  = (|(in_off & align_mask)) || ((in_size == SZ_D) && (WIDTH == 32));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_lane  <= '0;
      s1_size  <= SZ_B;
      s1_sign  <= 1'b0;
      s1_tag   <= '0;
      s1_err   <= 1'b0;
    end else begin
      if (s1_adv) begin
        s1_valid <= in_valid;
      end
      if (s1_load) begin
        s1_lane <= lane_d;
        s1_size <= size_e'(in_size);
        s1_sign <= in_sign;
        s1_tag  <= in_tag;
        s1_err  <= err_d;
      end
    end
  end

  // Extension. The lane is already zero above its access width, so only
  // the sign fill has to be ORed in; full-width accesses get an all-ones
  // mask and pass through unchanged.
  always_comb begin
    ext_mask = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (i < (32'd8 << s1_size)) begin
        ext_mask[i] = 1'b1;
      end
    end
    case (s1_size)
      SZ_B:    lane_msb = s1_lane[7];
      SZ_H:    lane_msb = s1_lane[15];
      SZ_W:    lane_msb = s1_lane[31];
      default: lane_msb = s1_lane[WIDTH-1];
    endcase
    ext_d = s1_lane | ({WIDTH{s1_sign && lane_msb}} & ~ext_mask);
    if (s1_err) begin
      ext_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      s2_valid <= 1'b0;
      s2_data  <= '0;
      s2_tag   <= '0;
      s2_err   <= 1'b0;
    end else begin
      if (s2_adv) begin
        s2_valid <= s1_valid;
      end
      if (s2_load) begin
        s2_data <= ext_d;
        s2_tag  <= s1_tag;
        s2_err  <= s1_err;
      end
    end
  end

  assign out_valid = s2_valid;
  assign out_data  = s2_data;
  assign out_tag   = s2_tag;
  assign out_err   = s2_err;

endmodule

// File: tb/tb_load_ext_pipe.sv
module tb_load_ext_pipe;

  logic        clk = 1'b0;
  logic        rst;

  // WIDTH=32 instance
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic [1:0]  in_off;
  logic [1:0]  in_size;
  logic        in_sign;
  logic [4:0]  in_tag;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [4:0]  out_tag;
  logic        out_err;

  // WIDTH=64 instance
  logic        w_in_valid;
  logic        w_in_ready;
  logic [63:0] w_in_data;
  logic [2:0]  w_in_off;
  logic [1:0]  w_in_size;
  logic        w_in_sign;
  logic [4:0]  w_in_tag;
  logic        w_out_valid;
  logic        w_out_ready;
  logic [63:0] w_out_data;
  logic [4:0]  w_out_tag;
  logic        w_out_err;

  int n_cmp = 0;
  int n_bad = 0;
  int edges = 0;

  load_ext_pipe #(.WIDTH(32), .TAG_W(5)) u32 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .in_off(in_off), .in_size(in_size), .in_sign(in_sign), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_tag(out_tag), .out_err(out_err)
  );

  load_ext_pipe #(.WIDTH(64), .TAG_W(5)) u64 (
    .clk(clk), .rst(rst),
    .in_valid(w_in_valid), .in_ready(w_in_ready), .in_data(w_in_data),
    .in_off(w_in_off), .in_size(w_in_size), .in_sign(w_in_sign), .in_tag(w_in_tag),
    .out_valid(w_out_valid), .out_ready(w_out_ready), .out_data(w_out_data),
    .out_tag(w_out_tag), .out_err(w_out_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edges <= edges + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference: an access of 2^size bytes must start on a multiple of its
  // size; dword does not exist on a 32-bit datapath.
  function automatic bit ref_err(input int off, input int size, input int width);
    int nb;
    nb = 1 << size;
    return ((off % nb) != 0) || (size == 3 && width == 32);
  endfunction

  function automatic longint unsigned ref_val(input longint unsigned data, input int off,
                                              input int size, input bit sgn, input int width);
    int nbits;
    longint unsigned v, m;
    nbits = 8 << size;
    if (ref_err(off, size, width)) return 64'd0;
    v = data >> (8 * off);
    if (nbits < 64) begin
      m = (64'd1 << nbits) - 64'd1;
      v = v & m;
      if (sgn && ((v >> (nbits - 1)) & 64'd1) != 64'd0) v = v | ~m;
    end
    if (width < 64) v = v & ((64'd1 << width) - 64'd1);
    return v;
  endfunction

  // Model of the 32-bit instance: a FIFO of accepted requests, each
  // visible at the output from the second edge after its acceptance.
  typedef struct {
    logic [31:0] data;
    logic [4:0]  tag;
    logic        err;
    int          acc;
  } exp_t;

  exp_t q[$];
  bit armed    = 1'b0;
  bit last_rst = 1'b0;

  always @(negedge clk) begin
    bit   exp_ov;
    bit   exp_ir;
    exp_t e;
    exp_ov = 1'b0;
    if (q.size() > 0) exp_ov = (edges >= q[0].acc + 1);
    // Two requests in flight fill both stages; only then can a stalled
    // consumer block new input.
    exp_ir = !((q.size() == 2) && !out_ready);
    if (armed) begin
      chk("in_ready", {63'd0, in_ready}, {63'd0, exp_ir});
      chk("out_valid", {63'd0, out_valid}, {63'd0, exp_ov});
      if (exp_ov) begin
        chk("out_data", {32'd0, out_data}, {32'd0, q[0].data});
        chk("out_tag", {59'd0, out_tag}, {59'd0, q[0].tag});
        chk("out_err", {63'd0, out_err}, {63'd0, q[0].err});
      end
      if (last_rst) begin
        chk("rst_data", {32'd0, out_data}, 64'd0);
        chk("rst_tag", {59'd0, out_tag}, 64'd0);
        chk("rst_err", {63'd0, out_err}, 64'd0);
      end
    end
    if (rst) begin
      q.delete();
      last_rst = 1'b1;
      armed    = 1'b1;
    end else begin
      last_rst = 1'b0;
      if (exp_ov && out_ready) void'(q.pop_front());
      if (in_valid && exp_ir) begin
        e.data = 32'(ref_val(64'(in_data), int'(in_off), int'(in_size), in_sign, 32));
        e.tag  = in_tag;
        e.err  = ref_err(int'(in_off), int'(in_size), 32);
        e.acc  = edges + 1;
        q.push_back(e);
      end
    end
  end

  // Single request into an empty 32-bit pipe; result must appear exactly
  // two cycles after acceptance. Entered and left just after a rising edge.
  task automatic dir32(input string nm, input logic [31:0] d, input int off, input int size,
                       input bit sg, input int tag, input logic [31:0] exp_d, input bit exp_e);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_data   = d;
    in_off    = 2'(off);
    in_size   = 2'(size);
    in_sign   = sg;
    in_tag    = 5'(tag);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk({nm, "_lat1"}, {63'd0, out_valid}, 64'd0);
    @(negedge clk);
    chk({nm, "_valid"}, {63'd0, out_valid}, 64'd1);
    chk({nm, "_data"}, {32'd0, out_data}, {32'd0, exp_d});
    chk({nm, "_tag"}, {59'd0, out_tag}, 64'(tag));
    chk({nm, "_err"}, {63'd0, out_err}, {63'd0, exp_e});
    @(posedge clk); #1;
  endtask

  task automatic dir64(input string nm, input logic [63:0] d, input int off, input int size,
                       input bit sg, input int tag, input logic [63:0] exp_d, input bit exp_e);
    w_out_ready = 1'b1;
    w_in_valid  = 1'b1;
    w_in_data   = d;
    w_in_off    = 3'(off);
    w_in_size   = 2'(size);
    w_in_sign   = sg;
    w_in_tag    = 5'(tag);
    @(posedge clk); #1;
    w_in_valid = 1'b0;
    @(negedge clk);
    chk({nm, "_lat1"}, {63'd0, w_out_valid}, 64'd0);
    @(negedge clk);
    chk({nm, "_valid"}, {63'd0, w_out_valid}, 64'd1);
    chk({nm, "_data"}, w_out_data, exp_d);
    chk({nm, "_model"}, w_out_data, ref_val(d, off, size, sg, 64));
    chk({nm, "_tag"}, {59'd0, w_out_tag}, 64'(tag));
    chk({nm, "_err"}, {63'd0, w_out_err}, {63'd0, exp_e});
    @(posedge clk); #1;
  endtask

  initial begin
    bit         acc;
    int         n_acc;
    int         first;
    int         last;
    logic [4:0] sent[$];
    logic [4:0] got[$];

    rst = 1'b1;
    in_valid = 1'b0; in_data = '0; in_off = '0; in_size = '0; in_sign = 1'b0; in_tag = '0;
    out_ready = 1'b1;
    w_in_valid = 1'b0; w_in_data = '0; w_in_off = '0; w_in_size = '0; w_in_sign = 1'b0;
    w_in_tag = '0; w_out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Pin the reference model to hand-computed values
    chk("pin_b_s", ref_val(64'h8899AABB, 1, 0, 1, 32), 64'hFFFFFFAA);
    chk("pin_b_z", ref_val(64'h8899AABB, 1, 0, 0, 32), 64'h000000AA);
    chk("pin_h_s", ref_val(64'h8899AABB, 2, 1, 1, 32), 64'hFFFF8899);
    chk("pin_w64", ref_val(64'h0123456789ABCDEF, 4, 2, 0, 64), 64'h0000000001234567);

    // Extension and misalignment on the 32-bit instance
    dir32("b_s",  32'h8899AABB, 1, 0, 1'b1, 1, 32'hFFFFFFAA, 1'b0);
    dir32("b_z",  32'h8899AABB, 1, 0, 1'b0, 2, 32'h000000AA, 1'b0);
    dir32("h_s",  32'h8899AABB, 2, 1, 1'b1, 3, 32'hFFFF8899, 1'b0);
    dir32("w",    32'h8899AABB, 0, 2, 1'b1, 4, 32'h8899AABB, 1'b0);
    dir32("mis_h", 32'h8899AABB, 1, 1, 1'b1, 5, 32'h00000000, 1'b1);
    dir32("mis_w", 32'h8899AABB, 2, 2, 1'b0, 6, 32'h00000000, 1'b1);
    dir32("bad_d", 32'h8899AABB, 0, 3, 1'b0, 7, 32'h00000000, 1'b1);

    // Back-to-back streaming: 8 requests, 8 consecutive results
    out_ready = 1'b1;
    first = -1; last = -1;
    got.delete();
    for (int k = 0; k < 12; k++) begin
      if (k < 8) begin
        in_valid = 1'b1;
        in_tag   = 5'(k);
        in_data  = $urandom;
        in_size  = 2'($urandom_range(0, 2));
        in_off   = 2'($urandom_range(0, 3));
        in_sign  = 1'($urandom_range(0, 1));
      end else begin
        in_valid = 1'b0;
      end
      @(negedge clk);
      if (out_valid) begin
        got.push_back(out_tag);
        if (first < 0) first = k;
        last = k;
      end
      @(posedge clk); #1;
    end
    chk("stream_count", 64'(got.size()), 64'd8);
    chk("stream_span", 64'(last - first), 64'd7);
    for (int i = 0; i < got.size(); i++) chk("stream_order", {59'd0, got[i]}, 64'(i));

    // Backpressure: consumer stalled while the producer keeps pushing
    out_ready = 1'b0;
    in_valid  = 1'b1;
    in_tag    = 5'd20;
    in_data   = $urandom; in_size = 2'd0; in_off = 2'($urandom_range(0, 3)); in_sign = 1'b1;
    n_acc = 0;
    sent.delete();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      acc = in_valid && in_ready;
      if (acc) begin
        n_acc++;
        sent.push_back(in_tag);
      end
      @(posedge clk); #1;
      if (acc) begin
        in_tag  = in_tag + 5'd1;
        in_data = $urandom;
      end
    end
    in_valid = 1'b0;
    chk("bp_accepts", 64'(n_acc), 64'd2);
    out_ready = 1'b1;
    got.delete();
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      if (out_valid) got.push_back(out_tag);
      @(posedge clk); #1;
    end
    chk("bp_drain_count", 64'(got.size()), 64'(sent.size()));
    for (int i = 0; i < sent.size(); i++) begin
      if (i < got.size()) chk("bp_drain_order", {59'd0, got[i]}, {59'd0, sent[i]});
    end

    // Reset with two requests in flight
    out_ready = 1'b0;
    in_valid  = 1'b1; in_tag = 5'd9; in_data = $urandom; in_size = 2'd2; in_off = 2'd0;
    @(posedge clk); #1;
    in_tag = 5'd10;
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      chk("rst_no_stale", {63'd0, out_valid}, 64'd0);
      @(posedge clk); #1;
    end

    // Randomised traffic with random backpressure and rare resets
    for (int c = 0; c < 1500; c++) begin
      @(negedge clk);
      acc = in_valid && in_ready && !rst;
      @(posedge clk); #1;
      rst       = ($urandom_range(0, 299) == 0);
      out_ready = ($urandom_range(0, 9) < 7);
      if (acc || !in_valid) begin
        in_valid = ($urandom_range(0, 9) < 8);
        in_data  = $urandom;
        in_off   = 2'($urandom_range(0, 3));
        in_size  = ($urandom_range(0, 9) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
        in_sign  = 1'($urandom_range(0, 1));
        in_tag   = 5'($urandom_range(0, 31));
      end
    end
    rst = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;

    // 64-bit instance
    dir64("w64_word",  64'h0123456789ABCDEF, 4, 2, 1'b0, 11, 64'h0000000001234567, 1'b0);
    dir64("w64_half",  64'h0123456789ABCDEF, 6, 1, 1'b1, 12, 64'h0000000000000123, 1'b0);
    dir64("w64_dword", 64'h0123456789ABCDEF, 0, 3, 1'b1, 13, 64'h0123456789ABCDEF, 1'b0);
    dir64("w64_byte",  64'h0123456789ABCDEF, 1, 0, 1'b1, 14, 64'hFFFFFFFFFFFFFFCD, 1'b0);
    dir64("w64_mis_d", 64'h0123456789ABCDEF, 4, 3, 1'b0, 15, 64'h0000000000000000, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
